// File: rtl/yapp_chan_rx.sv
// YAPP channel receiver: parses header/payload/parity from one router channel,
// buffers header and payload in a show-ahead FIFO and reports packet status.
module yapp_chan_rx #(
   parameter int         DEPTH      = 16,
   parameter int         SUSP_LEVEL = 12,
   parameter logic [1:0] CHAN_ADDR  = 2'd0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  data,
   input  logic        data_vld,
   output logic        suspend,
   input  logic        rd_en,
   output logic [7:0]  rd_data,
   output logic        rd_empty,
   output logic        pkt_done,
   output logic        pkt_err,
   output logic [15:0] pkt_count,
   output logic [15:0] err_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   SUSP_CNT = (AW+1)'(SUSP_LEVEL);

   typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY} state_t;

   state_t        state, next_state;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   fifo_count;
   logic [5:0]    remaining;
   logic [7:0]    parity;
   logic          hdr_bad;
   logic          vld_p0, wr_p0, pop_p0, par_p0;
   logic          vld_p1, err_p1;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign suspend  = (fifo_count >= SUSP_CNT);
   assign rd_empty = (fifo_count == '0);
   assign rd_data  = mem[rd_ptr];
   assign pkt_done = vld_p1;
   assign pkt_err  = err_p1;

   // Stage p0: byte acceptance and FIFO write/pop qualification
   assign vld_p0 = data_vld & ~suspend;
   assign par_p0 = vld_p0 & (state == PARITY);
   assign wr_p0  = vld_p0 & (state != PARITY);
   assign pop_p0 = rd_en & ~rd_empty;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (vld_p0) next_state = (data[7:2] == 6'd0) ? PARITY : PAYLOAD;
         PAYLOAD: if (vld_p0 && remaining == 6'd1) next_state = PARITY;
         PARITY:  if (vld_p0) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (wr_p0) mem[wr_ptr] <= data;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         remaining  <= '0;
         parity     <= '0;
         hdr_bad    <= 1'b0;
         vld_p1     <= 1'b0;
         err_p1     <= 1'b0;
         pkt_count  <= '0;
         err_count  <= '0;
      end else begin
         state <= next_state;
         if (wr_p0) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_p0) rd_ptr <= rd_ptr + PTR_ONE;
         case ({wr_p0, pop_p0})
            2'b10:   fifo_count <= fifo_count + CNT_ONE;
            2'b01:   fifo_count <= fifo_count - CNT_ONE;
            default: fifo_count <= fifo_count;
         endcase
         if (vld_p0) begin
            case (state)
               IDLE: begin
                  remaining <= data[7:2];
                  parity    <= data;
                  hdr_bad   <= (data[1:0] != CHAN_ADDR);
               end
               PAYLOAD: begin
                  remaining <= remaining - 6'd1;
                  parity    <= parity ^ data;
               end
               default: ;
            endcase
         end
         // Stage p1: packet status, one cycle after the parity byte
         vld_p1 <= par_p0;
         err_p1 <= par_p0 & ((data != parity) | hdr_bad);
         if (vld_p1) begin
            if (err_p1) err_count <= sat_inc(err_count);
            else        pkt_count <= sat_inc(pkt_count);
         end
      end
   end

endmodule

// File: tb/tb_yapp_chan_rx.sv
// Randomized self-checking bench for yapp_chan_rx against a packet/queue-level model.
module tb_yapp_chan_rx;

   localparam int SUSP = 12;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  data = 8'h00;
   logic        data_vld = 1'b0;
   logic        rd_en = 1'b0;
   logic        suspend;
   logic [7:0]  rd_data;
   logic        rd_empty;
   logic        pkt_done;
   logic        pkt_err;
   logic [15:0] pkt_count;
   logic [15:0] err_count;

   yapp_chan_rx #(.DEPTH(16), .SUSP_LEVEL(SUSP), .CHAN_ADDR(2'd0)) dut (
      .clock(clock), .reset(reset), .data(data), .data_vld(data_vld),
      .suspend(suspend), .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
      .pkt_done(pkt_done), .pkt_err(pkt_err), .pkt_count(pkt_count), .err_count(err_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   logic [7:0] fq[$];
   logic [7:0] bq[$];
   logic [7:0] pl[$];
   bit   pkt_bad;
   bit   done_exp = 0;
   bit   err_exp = 0;
   int   exp_pkt = 0;
   int   exp_err = 0;
   int   rd_mode = 0;
   int   gap_pct = 0;
   int   popped = 0;

   function automatic bit rd_pick();
      if (rd_mode == 2) return 1'($urandom_range(0, 1));
      return (rd_mode == 1);
   endfunction

   // One cycle: inputs driven at negedge, outputs compared to the model, model updated at posedge.
   task automatic step(input bit vld, input logic [7:0] b, input bit store, input bit last,
                       input bit bad, input bit rd, output bit acc);
      bit exp_susp;
      bit pop;
      data = b; data_vld = vld; rd_en = rd;
      exp_susp = (fq.size() >= SUSP);
      checks++;
      if (suspend !== exp_susp) begin
         errors++; $display("FAIL suspend got %b want %b (occupancy %0d)", suspend, exp_susp, fq.size());
      end
      checks++;
      if (rd_empty !== (fq.size() == 0)) begin
         errors++; $display("FAIL rd_empty got %b want %b", rd_empty, fq.size() == 0);
      end
      checks++;
      if (pkt_done !== done_exp) begin
         errors++; $display("FAIL pkt_done got %b want %b", pkt_done, done_exp);
      end
      checks++;
      if (pkt_err !== (done_exp & err_exp)) begin
         errors++; $display("FAIL pkt_err got %b want %b", pkt_err, done_exp & err_exp);
      end
      acc = vld && !exp_susp;
      pop = rd && (fq.size() > 0);
      if (pop) begin
         checks++;
         if (rd_data !== fq[0]) begin
            errors++; $display("FAIL rd_data got %h want %h", rd_data, fq[0]);
         end
      end
      done_exp = acc && last;
      err_exp  = bad;
      if (acc && last) begin
         if (bad) exp_err++;
         else     exp_pkt++;
      end
      @(posedge clock);
      if (pop) begin
         void'(fq.pop_front());
         popped++;
      end
      if (acc && store) fq.push_back(b);
      @(negedge clock);
      data_vld = 1'b0; rd_en = 1'b0;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, 0, acc);
   endtask

   task automatic drain();
      bit acc;
      int n = 0;
      while (fq.size() > 0 && n < 200) begin
         step(0, 8'h00, 0, 0, 0, 1, acc);
         n++;
      end
      checks++;
      if (rd_empty !== 1'b1) begin
         errors++; $display("FAIL drain_empty rd_empty got %b want 1", rd_empty);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0; data_vld = 1'b0; rd_en = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      fq.delete();
      done_exp = 0; err_exp = 0;
      exp_pkt = 0; exp_err = 0; popped = 0;
   endtask

   // Packet = header, payload (pl), XOR parity over header and payload.
   task automatic build_pkt(input logic [7:0] hdr, input bit corrupt);
      logic [7:0] x;
      bq.delete();
      bq.push_back(hdr);
      x = hdr;
      foreach (pl[i]) begin
         bq.push_back(pl[i]);
         x = x ^ pl[i];
      end
      bq.push_back(corrupt ? ~x : x);
      pkt_bad = corrupt || (hdr[1:0] != 2'd0);
   endtask

   task automatic send_range(input int lo, input int hi);
      bit acc;
      int n;
      for (int i = lo; i < hi; i++) begin
         if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) step(0, 8'h00, 0, 0, 0, rd_pick(), acc);
         acc = 0; n = 0;
         while (!acc && n < 300) begin
            step(1, bq[i], i != bq.size() - 1, i == bq.size() - 1, pkt_bad, rd_pick(), acc);
            n++;
         end
         if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout byte %0d not accepted after %0d cycles, want accepted", i, n);
            return;
         end
      end
   endtask

   task automatic random_pl(input int len);
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data = 8'($urandom); data_vld = 1'b1; rd_en = 1'b1;
         @(negedge clock);
      end
      data_vld = 1'b0; rd_en = 1'b0; reset = 1'b1;
      checks++;
      if (rd_empty !== 1'b1) begin errors++; $display("FAIL reset_rd_empty got %b want 1", rd_empty); end
      checks++;
      if (suspend !== 1'b0) begin errors++; $display("FAIL reset_suspend got %b want 0", suspend); end
      checks++;
      if (pkt_done !== 1'b0 || pkt_err !== 1'b0) begin
         errors++; $display("FAIL reset_pulses got %b%b want 00", pkt_done, pkt_err);
      end
      checks++;
      if (pkt_count !== 16'd0 || err_count !== 16'd0) begin
         errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", pkt_count, err_count);
      end
      fq.delete(); exp_pkt = 0; exp_err = 0; popped = 0;
      idle(2);
   endtask

   task automatic test_good();
      do_reset();
      rd_mode = 0; gap_pct = 0;
      pl = '{8'h11, 8'h22, 8'h33};
      build_pkt(8'h0C, 0);
      send_range(0, bq.size());
      idle(3);
      checks++;
      if (pkt_count !== 16'd1 || err_count !== 16'd0) begin
         errors++; $display("FAIL good_counts got %0d/%0d want 1/0", pkt_count, err_count);
      end
      drain();
      checks++;
      if (popped != 4) begin errors++; $display("FAIL good_popped got %0d want 4", popped); end
   endtask

   task automatic test_bad_parity();
      do_reset();
      pl = '{8'h11, 8'h22, 8'h33};
      build_pkt(8'h0C, 1);
      send_range(0, bq.size());
      idle(3);
      checks++;
      if (pkt_count !== 16'd0 || err_count !== 16'd1) begin
         errors++; $display("FAIL badpar_counts got %0d/%0d want 0/1", pkt_count, err_count);
      end
      drain();
      checks++;
      if (popped != 4) begin errors++; $display("FAIL badpar_popped got %0d want 4", popped); end
   endtask

   task automatic test_addr_mismatch();
      do_reset();
      random_pl(1);
      build_pkt(8'h05, 0);
      send_range(0, bq.size());
      idle(3);
      checks++;
      if (pkt_count !== 16'd0 || err_count !== 16'd1) begin
         errors++; $display("FAIL addr_counts got %0d/%0d want 0/1", pkt_count, err_count);
      end
      drain();
   endtask

   task automatic test_zero_len();
      do_reset();
      pl.delete();
      build_pkt(8'h00, 0);
      send_range(0, bq.size());
      idle(3);
      checks++;
      if (pkt_count !== 16'd1 || err_count !== 16'd0) begin
         errors++; $display("FAIL zero_counts got %0d/%0d want 1/0", pkt_count, err_count);
      end
      drain();
      checks++;
      if (popped != 1) begin errors++; $display("FAIL zero_popped got %0d want 1", popped); end
   endtask

   task automatic test_back_pressure();
      bit acc;
      do_reset();
      rd_mode = 0; gap_pct = 0;
      random_pl(20);
      build_pkt(8'h50, 0);
      send_range(0, 12);
      checks++;
      if (suspend !== 1'b1) begin errors++; $display("FAIL bp_suspend got %b want 1", suspend); end
      for (int i = 0; i < 3; i++) step(1, bq[12], 1, 0, 0, 0, acc);
      rd_mode = 1;
      send_range(12, bq.size());
      drain();
      idle(2);
      checks++;
      if (popped != 21) begin errors++; $display("FAIL bp_popped got %0d want 21", popped); end
      checks++;
      if (pkt_count !== 16'd1 || err_count !== 16'd0) begin
         errors++; $display("FAIL bp_counts got %0d/%0d want 1/0", pkt_count, err_count);
      end
      rd_mode = 0;
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      random_pl(5);
      build_pkt(8'h14, 0);
      send_range(0, 3);
      do_reset();
      checks++;
      if (rd_empty !== 1'b1) begin errors++; $display("FAIL mid_rd_empty got %b want 1", rd_empty); end
      idle(3);
      random_pl(2);
      build_pkt(8'h08, 0);
      send_range(0, bq.size());
      idle(3);
      checks++;
      if (pkt_count !== 16'd1 || err_count !== 16'd0) begin
         errors++; $display("FAIL mid_counts got %0d/%0d want 1/0", pkt_count, err_count);
      end
      drain();
   endtask

   task automatic test_random();
      logic [5:0] len;
      logic [1:0] addr;
      do_reset();
      rd_mode = 2; gap_pct = 30;
      for (int p = 0; p < 25; p++) begin
         len  = 6'($urandom_range(0, 14));
         addr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         random_pl(int'(len));
         build_pkt({len, addr}, $urandom_range(0, 4) == 0);
         send_range(0, bq.size());
      end
      drain();
      idle(3);
      checks++;
      if (pkt_count !== 16'(exp_pkt) || err_count !== 16'(exp_err)) begin
         errors++; $display("FAIL random_counts got %0d/%0d want %0d/%0d", pkt_count, err_count, exp_pkt, exp_err);
      end
      rd_mode = 0; gap_pct = 0;
   endtask

   initial begin
      @(negedge clock);
      test_reset();
      test_good();
      test_bad_parity();
      test_addr_mismatch();
      test_zero_len();
      test_back_pressure();
      test_reset_mid_packet();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
